// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer for the ZAFx32 core.
//   Keeps the word-addressed PC. Issues one instruction-memory request at a time
//   over a req/gnt/rvalid handshake. Hands {instruction, PC, PC+1} to decode
//   through a single-entry valid/ready buffer. A taken branch/jump from execute
//   redirects the PC and flushes whatever is buffered or in flight.
//
// Ports
//   clock          in   rising-edge clock
//   resetN         in   asynchronous active-low reset
//   redirectValid  in   taken branch/jump this cycle (highest priority)
//   redirectPC     in   redirect target word address
//   imemReq        out  fetch request, held until imemGnt
//   imemAddr       out  fetch word address (always the current pc)
//   imemGnt        in   memory accepted the request this cycle
//   imemRValid     in   read data valid, one per granted request
//   imemRData      in   read data
//   instValid      out  buffered instruction valid
//   instData       out  buffered instruction
//   instPC         out  address of instData
//   instPCPlus1    out  instPC + 1 (link value), combinational
//   instReady      in   decode accepts the buffered instruction
//
// Address vectors are numbered [0:ADDR_W-1] with bit 0 as the MSB. Arithmetic on
// them is ordinary unsigned arithmetic and wraps modulo 2^ADDR_W.

module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [0:ADDR_W-1] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              redirectValid,
  input  logic [0:ADDR_W-1] redirectPC,
  output logic              imemReq,
  output logic [0:ADDR_W-1] imemAddr,
  input  logic              imemGnt,
  input  logic              imemRValid,
  input  logic [DATA_W-1:0] imemRData,
  output logic              instValid,
  output logic [DATA_W-1:0] instData,
  output logic [0:ADDR_W-1] instPC,
  output logic [0:ADDR_W-1] instPCPlus1,
  input  logic              instReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetchState_t;

  fetchState_t       stateReg, stateNext;
  logic [0:ADDR_W-1] pcReg, pcNext;
  logic [0:ADDR_W-1] reqPCReg, reqPCNext;
  logic              squashReg, squashNext;
  logic              instValidReg, instValidNext;
  logic [DATA_W-1:0] instDataReg, instDataNext;
  logic [0:ADDR_W-1] instPCReg, instPCNext;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateReg     <= IDLE;
      pcReg        <= RESET_PC;
      reqPCReg     <= '0;
      squashReg    <= 1'b0;
      instValidReg <= 1'b0;
      instDataReg  <= '0;
      instPCReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      reqPCReg     <= reqPCNext;
      squashReg    <= squashNext;
      instValidReg <= instValidNext;
      instDataReg  <= instDataNext;
      instPCReg    <= instPCNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    reqPCNext     = reqPCReg;
    squashNext    = squashReg;
    instValidNext = instValidReg;
    instDataNext  = instDataReg;
    instPCNext    = instPCReg;

    if (redirectValid) begin
      // Redirect wins over grant, read data and decode acceptance in the
      // same cycle: the buffer is flushed and fetching resumes at the target.
      pcNext        = redirectPC;
      instValidNext = 1'b0;
      unique case (stateReg)
        IDLE, HOLD: stateNext = REQ;
        REQ: begin
          if (imemGnt) begin
            // The old-address request was accepted this very cycle; its
            // response must be thrown away when it shows up.
            reqPCNext  = pcReg;
            squashNext = 1'b1;
            stateNext  = WAIT;
          end
        end
        WAIT: begin
          if (imemRValid) begin
            squashNext = 1'b0;
            stateNext  = REQ;
          end else begin
            squashNext = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else begin
      unique case (stateReg)
        IDLE: stateNext = REQ;
        REQ: begin
          if (imemGnt) begin
            reqPCNext = pcReg;
            stateNext = WAIT;
          end
        end
        WAIT: begin
          if (imemRValid) begin
            if (squashReg) begin
              squashNext = 1'b0;
              stateNext  = REQ;
            end else begin
              instDataNext  = imemRData;
              instPCNext    = reqPCReg;
              instValidNext = 1'b1;
              pcNext        = reqPCReg + ADDR_W'(1);
              stateNext     = HOLD;
            end
          end
        end
        HOLD: begin
          if (instReady) begin
            instValidNext = 1'b0;
            stateNext     = REQ;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign imemReq     = (stateReg == REQ);
  assign imemAddr    = pcReg;
  assign instValid   = instValidReg;
  assign instData    = instDataReg;
  assign instPC      = instPCReg;
  assign instPCPlus1 = instPCReg + ADDR_W'(1);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clock;
  logic        resetN;
  logic        redirectValid;
  logic [0:31] redirectPC;
  logic        imemReq;
  logic [0:31] imemAddr;
  logic        imemGnt;
  logic        imemRValid;
  logic [31:0] imemRData;
  logic        instValid;
  logic [31:0] instData;
  logic [0:31] instPC;
  logic [0:31] instPCPlus1;
  logic        instReady;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'd0)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .redirectValid(redirectValid),
    .redirectPC   (redirectPC),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemGnt      (imemGnt),
    .imemRValid   (imemRValid),
    .imemRData    (imemRData),
    .instValid    (instValid),
    .instData     (instData),
    .instPC       (instPC),
    .instPCPlus1  (instPCPlus1),
    .instReady    (instReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  // Grants immediately while gntEn is set; returns addr^A5A50000 rvLag cycles
  // after the grant. forceRValid injects an unsolicited response.
  logic        gntEn;
  int          rvLag;
  logic        forceRValid;
  logic [31:0] forceData;
  logic        memPend;
  logic        memRv;
  int          memSince;
  logic [31:0] memAddr;

  initial begin
    memPend  = 1'b0;
    memRv    = 1'b0;
    memSince = 0;
    memAddr  = '0;
  end

  assign imemGnt    = gntEn & imemReq;
  assign imemRValid = forceRValid | memRv;
  assign imemRData  = forceRValid ? forceData : (memAddr ^ 32'hA5A5_0000);

  always @(posedge clock) begin
    if (!resetN) begin
      memPend <= 1'b0;
      memRv   <= 1'b0;
    end else if (imemReq && imemGnt) begin
      memPend  <= 1'b1;
      memAddr  <= imemAddr;
      memSince <= 1;
      memRv    <= (rvLag <= 1);
    end else if (memPend) begin
      if (memRv) begin
        memPend <= 1'b0;
        memRv   <= 1'b0;
      end else begin
        memSince <= memSince + 1;
        memRv    <= (memSince + 1 >= rvLag);
      end
    end
  end

  logic [31:0] fetchLog[$];
  always @(posedge clock) begin
    if (resetN && imemReq && imemGnt) fetchLog.push_back(imemAddr);
  end

  // ---------------- behavioural reference model ----------------
  // Tracks the fetcher as abstract facts: has it started, is a request in
  // flight, is that response stale, is the decode buffer occupied.
  logic        mStarted, mInFlight, mStale, mBufFull;
  logic [31:0] mBufData, mBufPC, mPc, mReqAddr;
  logic        wantReq;
  logic [31:0] expPlus1;

  assign wantReq  = mStarted && !mInFlight && !mBufFull;
  assign expPlus1 = mBufPC + 32'd1;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mStarted  <= 1'b0;
      mInFlight <= 1'b0;
      mStale    <= 1'b0;
      mBufFull  <= 1'b0;
      mBufData  <= '0;
      mBufPC    <= '0;
      mPc       <= 32'd0;
      mReqAddr  <= '0;
    end else begin
      mStarted <= 1'b1;
      if (redirectValid) begin
        mPc      <= redirectPC;
        mBufFull <= 1'b0;
        if (wantReq && imemGnt) begin
          mInFlight <= 1'b1;
          mStale    <= 1'b1;
        end else if (mInFlight) begin
          if (imemRValid) begin
            mInFlight <= 1'b0;
            mStale    <= 1'b0;
          end else begin
            mStale <= 1'b1;
          end
        end
      end else if (wantReq && imemGnt) begin
        mInFlight <= 1'b1;
        mReqAddr  <= mPc;
      end else if (mInFlight && imemRValid) begin
        mInFlight <= 1'b0;
        if (mStale) begin
          mStale <= 1'b0;
        end else begin
          mBufFull <= 1'b1;
          mBufData <= imemRData;
          mBufPC   <= mReqAddr;
          mPc      <= mReqAddr + 32'd1;
        end
      end else if (mBufFull && instReady) begin
        mBufFull <= 1'b0;
      end
    end
  end

  logic [31:0] delPC[$];
  logic [31:0] delData[$];

  always @(negedge clock) begin
    if (!resetN) begin
      chk("rst_imemReq", imemReq, 1'b0);
      chk("rst_instValid", instValid, 1'b0);
    end else begin
      chk("cyc_imemReq", imemReq, wantReq);
      if (wantReq) chk("cyc_imemAddr", imemAddr, mPc);
      chk("cyc_instValid", instValid, mBufFull);
      if (mBufFull) begin
        chk("cyc_instData", instData, mBufData);
        chk("cyc_instPC", instPC, mBufPC);
        chk("cyc_instPCPlus1", instPCPlus1, expPlus1);
      end
      if (instValid && instReady && !redirectValid) begin
        $display("TXN deliver pc=%h data=%h link=%h", instPC, instData, instPCPlus1);
        delPC.push_back(instPC);
        delData.push_back(instData);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (instValid !== 1'b1 && n < 30) begin
      cyc(1);
      n++;
    end
    chk(name, instValid, 1'b1);
  endtask

  task automatic chkLog(input string name, input int idx, input logic [31:0] exp);
    if (fetchLog.size() > idx) chk(name, fetchLog[idx], exp);
    else chk(name, 64'hFFFF_FFFF_FFFF_FFFF, exp);
  endtask

  initial begin
    int idx;
    resetN        = 1'b0;
    redirectValid = 1'b0;
    redirectPC    = '0;
    instReady     = 1'b1;
    gntEn         = 1'b1;
    rvLag         = 1;
    forceRValid   = 1'b0;
    forceData     = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_imemReq", imemReq, 1'b0);
    chk("reset_instValid", instValid, 1'b0);
    chk("reset_instData", instData, 32'd0);
    chk("reset_instPC", instPC, 32'd0);
    chk("reset_imemAddr", imemAddr, 32'd0);

    // 1. straight-line fetch
    resetN = 1'b1;
    cyc(1);
    chk("t1_req_latency", imemReq, 1'b1);
    chk("t1_addr0", imemAddr, 32'd0);
    cyc(2);
    chk("t1_valid_latency", instValid, 1'b1);
    chk("t1_pc0", instPC, 32'd0);
    chk("t1_data0", instData, 32'hA5A5_0000);
    chk("t1_link0", instPCPlus1, 32'd1);
    cyc(13);
    for (int i = 0; i < 4; i++) begin
      chkLog("t1_fetch_addr", i, i);
      if (delPC.size() > i) begin
        chk("t1_del_pc", delPC[i], i);
        chk("t1_del_data", delData[i], 32'hA5A5_0000 | i);
      end else begin
        chk("t1_del_count", delPC.size(), i + 1);
      end
    end
    instReady = 1'b0;

    // 2. decode stall on instPC=5
    cyc(2);
    repeat (5) begin
      cyc(1);
      chk("t2_hold_valid", instValid, 1'b1);
      chk("t2_hold_pc", instPC, 32'd5);
      chk("t2_hold_noreq", imemReq, 1'b0);
    end
    chk("t2_hold_data", instData, 32'hA5A5_0005);
    instReady = 1'b1;
    cyc(1);
    chk("t2_req_after", imemReq, 1'b1);
    chk("t2_addr6", imemAddr, 32'd6);

    // 3. redirect while holding
    instReady = 1'b0;
    cyc(2);
    chk("t3_hold_pc6", instPC, 32'd6);
    redirectValid = 1'b1;
    redirectPC    = 32'h40;
    cyc(1);
    redirectValid = 1'b0;
    chk("t3_flush", instValid, 1'b0);
    chk("t3_req", imemReq, 1'b1);
    chk("t3_addr", imemAddr, 32'h40);
    cyc(2);
    chk("t3_valid", instValid, 1'b1);
    chk("t3_pc", instPC, 32'h40);
    chk("t3_data", instData, 32'hA5A5_0040);

    // 4a. redirect during WAIT, slow stale response
    rvLag     = 4;
    instReady = 1'b1;
    cyc(1);
    instReady = 1'b0;
    cyc(1);
    chk("t4a_in_wait", imemReq, 1'b0);
    redirectValid = 1'b1;
    redirectPC    = 32'h80;
    cyc(1);
    redirectValid = 1'b0;
    idx = fetchLog.size();
    waitValid("t4a_timeout");
    chk("t4a_pc", instPC, 32'h80);
    chk("t4a_data", instData, 32'hA5A5_0080);
    chkLog("t4a_next_fetch", idx, 32'h80);

    // 4b. redirect coincident with the grant
    instReady = 1'b1;
    cyc(1);
    instReady     = 1'b0;
    redirectValid = 1'b1;
    redirectPC    = 32'hC0;
    cyc(1);
    redirectValid = 1'b0;
    idx = fetchLog.size();
    chk("t4b_in_wait", imemReq, 1'b0);
    waitValid("t4b_timeout");
    chk("t4b_pc", instPC, 32'hC0);
    chkLog("t4b_next_fetch", idx, 32'hC0);

    // 5. redirect in REQ without grant, to the top of the address space
    rvLag     = 1;
    gntEn     = 1'b0;
    instReady = 1'b1;
    cyc(2);
    chk("t5_req_stall", imemReq, 1'b1);
    chk("t5_addr_c1", imemAddr, 32'hC1);
    instReady     = 1'b0;
    redirectValid = 1'b1;
    redirectPC    = 32'hFFFF_FFFF;
    cyc(1);
    redirectValid = 1'b0;
    chk("t5_req_kept", imemReq, 1'b1);
    chk("t5_addr_top", imemAddr, 32'hFFFF_FFFF);
    gntEn = 1'b1;
    cyc(2);
    chk("t5_valid", instValid, 1'b1);
    chk("t5_pc", instPC, 32'hFFFF_FFFF);
    chk("t5_link_wrap", instPCPlus1, 32'd0);
    chk("t5_data", instData, 32'h5A5A_FFFF);
    instReady = 1'b1;
    cyc(1);
    chk("t5_wrap_req", imemReq, 1'b1);
    chk("t5_wrap_addr", imemAddr, 32'd0);

    // 6. asynchronous reset mid-WAIT
    rvLag     = 3;
    instReady = 1'b0;
    cyc(1);
    chk("t6_in_wait", imemReq, 1'b0);
    #3;
    resetN = 1'b0;
    #1;
    chk("t6_async_req", imemReq, 1'b0);
    chk("t6_async_valid", instValid, 1'b0);
    chk("t6_async_data", instData, 32'd0);
    chk("t6_async_pc", instPC, 32'd0);
    chk("t6_async_addr", imemAddr, 32'd0);
    @(posedge clock);
    #1;
    rvLag       = 1;
    resetN      = 1'b1;
    forceRValid = 1'b1;
    forceData   = 32'hDEAD_BEEF;
    cyc(1);
    forceRValid = 1'b0;
    chk("t6_restart_req", imemReq, 1'b1);
    chk("t6_restart_addr", imemAddr, 32'd0);
    chk("t6_ignored_rvalid", instValid, 1'b0);
    cyc(2);
    chk("t6_valid", instValid, 1'b1);
    chk("t6_pc", instPC, 32'd0);
    chk("t6_data", instData, 32'hA5A5_0000);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
